// File: rtl/conv5_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv5_seq_ctrl
//  Description : Sequencer for the 5x5 convolution datapath. On start it
//                reads the kernel rows into the datapath, then streams the
//                image one 5-pixel column per cycle, band by band. Every
//                column that completes a window is tagged with its output
//                (row, col). The tag travels down a latency pipeline matched
//                to the datapath so it appears next to the result.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - begin a frame (IDLE only)
//                busy, done          - frame in progress / end-of-frame pulse
//                kern_rd_en/addr     - kernel buffer row read
//                img_rd_en/row/col   - image column read (top row of band)
//                conv_kernel_load    - datapath kernel_load
//                conv_valid_in       - datapath valid_in
//                conv_valid_out      - datapath valid_out
//                res_valid/row/col   - tagged result qualifier
//  Revision    : 1.0 - initial release
// ============================================================================
module conv5_seq_ctrl #(
    parameter int KERNEL_SIZE = 5,
    parameter int IMG_SIZE    = 32,
    parameter int RES_LAT     = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              kern_rd_en,
    output logic [2:0]        kern_addr,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_row,
    output logic [ADDR_W-1:0] img_col,
    output logic              conv_kernel_load,
    output logic              conv_valid_in,
    output logic              conv_valid_out,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_row,
    output logic [ADDR_W-1:0] res_col
);

    localparam int c_LAST_K   = KERNEL_SIZE - 1;
    localparam int c_LAST_ROW = IMG_SIZE - KERNEL_SIZE;
    localparam int c_LAST_COL = IMG_SIZE - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KLOAD  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [2:0]          r_kcnt;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   r_col;

    logic                r_kload_d;
    logic                r_vin_d;

    // Tag stage aligned with conv_valid_in of the fetch that closes a window.
    logic                r_tap_v;
    logic [ADDR_W-1:0]   r_tap_row;
    logic [ADDR_W-1:0]   r_tap_col;

    // RES_LAT-deep tag pipeline; the last stage lines up with valid_out.
    logic [RES_LAT-1:0]  r_pipe_v;
    logic [ADDR_W-1:0]   r_pipe_row [RES_LAT];
    logic [ADDR_W-1:0]   r_pipe_col [RES_LAT];

    logic                r_res_v;
    logic [ADDR_W-1:0]   r_res_row;
    logic [ADDR_W-1:0]   r_res_col;

    logic                w_k_last;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_win;
    logic                w_inflight;

    assign w_k_last   = (r_kcnt == 3'(c_LAST_K));
    assign w_col_last = (r_col == ADDR_W'(c_LAST_COL));
    assign w_row_last = (r_row == ADDR_W'(c_LAST_ROW));
    // Columns left of KERNEL_SIZE-1 still hold pixels of the previous band.
    assign w_win      = (r_state == S_STREAM) && (r_col >= ADDR_W'(c_LAST_K));
    // res_valid of the final tag is the cycle where this first drops to 0.
    assign w_inflight = r_tap_v | (|r_pipe_v);

    always_comb begin
        w_next           = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        kern_rd_en       = 1'b0;
        img_rd_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_KLOAD;
            end
            S_KLOAD: begin
                busy       = 1'b1;
                kern_rd_en = 1'b1;
                if (w_k_last) w_next = S_STREAM;
            end
            S_STREAM: begin
                busy      = 1'b1;
                img_rd_en = 1'b1;
                if (w_row_last && w_col_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!w_inflight) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign kern_addr        = r_kcnt;
    assign img_row          = r_row;
    assign img_col          = r_col;
    assign conv_kernel_load = r_kload_d;
    assign conv_valid_in    = r_vin_d;
    assign conv_valid_out   = r_pipe_v[RES_LAT-1];
    assign res_valid        = r_res_v;
    assign res_row          = r_res_row;
    assign res_col          = r_res_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_kcnt    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_kload_d <= 1'b0;
            r_vin_d   <= 1'b0;
            r_tap_v   <= 1'b0;
            r_tap_row <= '0;
            r_tap_col <= '0;
            r_pipe_v  <= '0;
            for (int i = 0; i < RES_LAT; i++) begin
                r_pipe_row[i] <= '0;
                r_pipe_col[i] <= '0;
            end
            r_res_v   <= 1'b0;
            r_res_row <= '0;
            r_res_col <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_KLOAD && !w_k_last) r_kcnt <= r_kcnt + 3'd1;
            else                                 r_kcnt <= '0;

            if (r_state == S_STREAM) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + ADDR_W'(1);
                end else begin
                    r_col <= r_col + ADDR_W'(1);
                end
            end else begin
                r_row <= '0;
                r_col <= '0;
            end

            r_kload_d <= kern_rd_en;
            r_vin_d   <= kern_rd_en | img_rd_en;

            r_tap_v   <= w_win;
            r_tap_row <= r_row;
            r_tap_col <= r_col - ADDR_W'(c_LAST_K);

            r_pipe_v[0]   <= r_tap_v;
            r_pipe_row[0] <= r_tap_row;
            r_pipe_col[0] <= r_tap_col;
            for (int i = 1; i < RES_LAT; i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_row[i] <= r_pipe_row[i-1];
                r_pipe_col[i] <= r_pipe_col[i-1];
            end

            r_res_v <= r_pipe_v[RES_LAT-1];
            if (r_pipe_v[RES_LAT-1]) begin
                r_res_row <= r_pipe_row[RES_LAT-1];
                r_res_col <= r_pipe_col[RES_LAT-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv5_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv5_seq_ctrl
//  Description : Directed self-checking bench for conv5_seq_ctrl. Cycle 0 of
//                a frame is the cycle in which start is presented in IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv5_seq_ctrl;

    localparam int c_ADDR_W = 6;
    localparam int c_OUT_N  = 28;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                kern_rd_en;
    logic [2:0]          kern_addr;
    logic                img_rd_en;
    logic [c_ADDR_W-1:0] img_row;
    logic [c_ADDR_W-1:0] img_col;
    logic                conv_kernel_load;
    logic                conv_valid_in;
    logic                conv_valid_out;
    logic                res_valid;
    logic [c_ADDR_W-1:0] res_row;
    logic [c_ADDR_W-1:0] res_col;

    int n_vec  = 0;
    int n_miss = 0;
    int n_res  = 0;

    conv5_seq_ctrl #(
        .KERNEL_SIZE (5),
        .IMG_SIZE    (32),
        .RES_LAT     (2),
        .ADDR_W      (c_ADDR_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .kern_rd_en       (kern_rd_en),
        .kern_addr        (kern_addr),
        .img_rd_en        (img_rd_en),
        .img_row          (img_row),
        .img_col          (img_col),
        .conv_kernel_load (conv_kernel_load),
        .conv_valid_in    (conv_valid_in),
        .conv_valid_out   (conv_valid_out),
        .res_valid        (res_valid),
        .res_row          (res_row),
        .res_col          (res_col)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, kern_rd_en, kern_addr, img_rd_en, img_row, img_col,
                    conv_kernel_load, conv_valid_in, conv_valid_out,
                    res_valid, res_row, res_col});
    endfunction

    // Expectations for frame-relative cycle rc.
    task automatic check_cycle(input int rc);
        if (rc <= 8) begin
            check_eq($sformatf("kern_rd_en@%0d", rc), 64'(kern_rd_en), 64'(rc >= 1 && rc <= 5));
            check_eq($sformatf("kload@%0d", rc), 64'(conv_kernel_load), 64'(rc >= 2 && rc <= 6));
            check_eq($sformatf("vin@%0d", rc), 64'(conv_valid_in), 64'(rc >= 2));
        end
        if (rc >= 1 && rc <= 5)
            check_eq($sformatf("kern_addr@%0d", rc), 64'(kern_addr), 64'(rc - 1));
        if (rc == 5 || rc == 6 || rc == 901 || rc == 902)
            check_eq($sformatf("img_rd_en@%0d", rc), 64'(img_rd_en), 64'(rc == 6 || rc == 901));
        if (rc == 6)   check_eq("img_pos@6",   64'({img_row, img_col}), {52'd0, 6'd0,  6'd0});
        if (rc == 37)  check_eq("img_pos@37",  64'({img_row, img_col}), {52'd0, 6'd0,  6'd31});
        if (rc == 38)  check_eq("img_pos@38",  64'({img_row, img_col}), {52'd0, 6'd1,  6'd0});
        if (rc == 901) check_eq("img_pos@901", 64'({img_row, img_col}), {52'd0, 6'd27, 6'd31});
        if (rc == 903) check_eq("vin@903", 64'(conv_valid_in), 64'd0);
        if (rc == 12 || rc == 13)
            check_eq($sformatf("vout@%0d", rc), 64'(conv_valid_out), 64'(rc == 13));
        if (rc == 13 || rc == 906 || (rc >= 42 && rc <= 45))
            check_eq($sformatf("res_valid@%0d", rc), 64'(res_valid), 64'd0);
        if (rc == 14 || rc == 15 || rc == 41 || rc == 46 || rc == 905)
            check_eq($sformatf("res_valid@%0d", rc), 64'(res_valid), 64'd1);
        if (rc == 14)  check_eq("tag@14",  64'({res_row, res_col}), {52'd0, 6'd0,  6'd0});
        if (rc == 15)  check_eq("tag@15",  64'({res_row, res_col}), {52'd0, 6'd0,  6'd1});
        if (rc == 41)  check_eq("tag@41",  64'({res_row, res_col}), {52'd0, 6'd0,  6'd27});
        if (rc == 46)  check_eq("tag@46",  64'({res_row, res_col}), {52'd0, 6'd1,  6'd0});
        if (rc == 905) check_eq("tag@905", 64'({res_row, res_col}), {52'd0, 6'd27, 6'd27});
        if (rc == 0 || rc == 1 || rc == 905 || rc == 906 || rc == 907)
            check_eq($sformatf("busy@%0d", rc), 64'(busy), 64'(rc >= 1 && rc <= 905));
        if (rc == 905 || rc == 906 || rc == 907)
            check_eq($sformatf("done@%0d", rc), 64'(done), 64'(rc == 906));
        // Results appear in raster order over the 28x28 output grid.
        if (res_valid) begin
            check_eq("res_order", 64'({res_row, res_col}),
                     64'({6'(n_res / c_OUT_N), 6'(n_res % c_OUT_N)}));
            n_res++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset_outs", all_outs(), 64'd0);

        // Frame 1, with stray starts at 100 (STREAM) and 906 (DONE).
        start = 1'b1;
        n_res = 0;
        check_cycle(0);
        for (int c = 1; c <= 907; c++) begin
            tick();
            start = (c == 100 || c == 906 || c == 907);
            check_cycle(c);
        end
        check_eq("res_count", 64'(n_res), 64'd784);

        // Frame 2 began with start at 907; abort it with reset at its cycle 300.
        n_res = 0;
        for (int rc = 1; rc <= 300; rc++) begin
            tick();
            start = 1'b0;
            check_cycle(rc);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_outs", all_outs(), 64'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("abort_idle", 64'({busy, done, res_valid, conv_valid_out}), 64'd0);
        end

        // Frame 3 must reproduce the cycle-0 timing.
        start = 1'b1;
        n_res = 0;
        check_cycle(0);
        for (int rc = 1; rc <= 50; rc++) begin
            tick();
            start = 1'b0;
            check_cycle(rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv5_seq_ctrl.md
Name: conv5_seq_ctrl

Overview:
- Sequencer for the 5x5 convolution datapath in layer_0.
- On start, it loads the 5 kernel rows into the datapath, then streams the image column by column, one column of 5 vertical pixels per cycle.
- It drives the datapath strobes `kernel_load`, `valid_in` and `valid_out`, and tags every valid convolution result with its output (row, col).
- It sits between the image/kernel buffers and the conv datapath; the data muxing to the datapath `data_in0..4` lies outside this block.

Parameters:
- `KERNEL_SIZE`, 5, kernel height/width.
- `IMG_SIZE`, 32, square input image dimension.
- `RES_LAT`, 2, cycles from the `conv_valid_in` that completes a window to the `conv_valid_out` pulse that publishes it.
- `ADDR_W`, 6, width of row/col address and tag outputs; must satisfy 2^`ADDR_W` >= `IMG_SIZE`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle pulse at frame end
- `kern_rd_en`  out  1  kernel buffer read strobe
- `kern_addr`  out  3  kernel row index, 0..`KERNEL_SIZE`-1
- `img_rd_en`  out  1  image column read strobe
- `img_row`  out  `ADDR_W`  top row of the 5-row band
- `img_col`  out  `ADDR_W`  column index
- `conv_kernel_load`  out  1  datapath `kernel_load`
- `conv_valid_in`  out  1  datapath `valid_in`
- `conv_valid_out`  out  1  datapath `valid_out`
- `res_valid`  out  1  datapath `data_out` holds a valid result this cycle
- `res_row`  out  `ADDR_W`  output row of the current result
- `res_col`  out  `ADDR_W`  output col of the current result

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latency pipeline cleared. Reset mid-frame aborts immediately; no `done` is issued and in-flight tags are discarded.
- Buffer reads have 1-cycle latency. `conv_valid_in` is `kern_rd_en | img_rd_en` delayed by 1 cycle. `conv_kernel_load` is `kern_rd_en` delayed by 1 cycle.
- States: IDLE, KLOAD, STREAM, DRAIN, DONE.
- IDLE: `start`=1 -> KLOAD; `start` is ignored in every other state.
- KLOAD: `kern_rd_en`=1 for `KERNEL_SIZE` consecutive cycles with `kern_addr` 0,1,..,4. After addr 4 -> STREAM with no gap cycle.
- STREAM: `img_rd_en`=1 every cycle.
  - Order is `img_col` 0..`IMG_SIZE`-1 inside `img_row` 0..`IMG_SIZE`-`KERNEL_SIZE`.
  - Row advance is back-to-back: col `IMG_SIZE`-1 of row r is followed next cycle by col 0 of row r+1.
  - After the last (row 27, col 31) -> DRAIN.
- A column fetched with `img_col` c >= `KERNEL_SIZE`-1 completes a window. Its tag (r, c-`KERNEL_SIZE`+1) enters a `RES_LAT`-deep valid/tag shift pipeline, timed from its `conv_valid_in` cycle. Columns with c < 4 complete no window: they carry stale columns from the previous band and produce no tag.
- When a tag exits the pipeline, `conv_valid_out`=1. In the next cycle `res_valid`=1, with `res_row`/`res_col` equal to the tag.
- DRAIN: no reads. Wait until the pipeline is empty and the last `res_valid` has been issued -> DONE.
- DONE: `done`=1 for one cycle, `busy`=0 in that cycle -> IDLE.
- `start` asserted in the DONE cycle is ignored; it is accepted from IDLE on the next cycle.
- Results per frame: (`IMG_SIZE`-`KERNEL_SIZE`+1)^2 = 784. `res_col` counts 0..27 and never wraps into the tag of the next row.
- Counters wrap only via explicit compare-to-limit, never via natural overflow.

Test Plan:
- Kernel load: `start` at cycle 0 -> `kern_rd_en` cycles 1-5, addr 0..4; `conv_valid_in` and `conv_kernel_load` high cycles 2-6; `conv_kernel_load` low thereafter.
- First results: `img_rd_en` from cycle 6 (row 0, col 0); `conv_valid_out` first at cycle 13; `res_valid` at 14 with (0,0); (0,1) at 15; (0,27) at 41.
- Row boundary: fetch (1,0) in the cycle after (0,31); no `res_valid` for fetches (1,0)-(1,3); next result (1,0) at cycle 46.
- Full frame: exactly 784 `res_valid` pulses; last tag (27,27) at cycle 905; `done` at 906; `busy` high cycles 1-905.
- `start` pulsed at cycles 100 and 906 -> ignored; no restart, count stays 784. `start` at 907 -> new frame begins.
- Reset at cycle 300 -> next cycle all outputs 0, state IDLE, no `done`. A subsequent `start` reproduces the cycle-0 timing.
